// File: rtl/bsg_sync_gray_ptr_rx_pkg.sv
// Shared constants and helpers for the Gray pointer receive endpoint.
package bsg_sync_gray_ptr_rx_pkg;

  localparam int unsigned default_width_lp = 4;

  // Ones count of a zero-extended difference vector
  function automatic logic [5:0] popcount32(input logic [31:0] vec);
    logic [5:0] ones;
    ones = '0;
    for (int i = 0; i < 32; i++) begin
      ones = ones + {5'd0, vec[i]};
    end
    return ones;
  endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Purely combinational Gray-to-binary decoder, shared by async pointer users.
module bsg_gray_to_binary #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at and above its position
  for (genvar i = 0; i < width_p; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/bsg_sync_gray_ptr_rx.sv
// Receive-side endpoint for a synchronized Gray producer pointer with valid/yumi drain.
// Optional multi-bit-change checker: define BSG_SYNC_GRAY_PTR_RX_CHECK_EN.
module bsg_sync_gray_ptr_rx
  import bsg_sync_gray_ptr_rx_pkg::*;
#(
  parameter int width_p = default_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] gray_ptr_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] count_o,
  output logic [width_p-1:0] ptr_o,
  output logic               error_o
);

  logic [width_p-1:0] gray_r;
  logic [width_p-1:0] bin_r;
  logic [width_p-1:0] ptr_r;
  logic [width_p-1:0] bin_next;

  bsg_gray_to_binary #(.width_p(width_p)) g2b (
    .gray_i(gray_r),
    .bin_o (bin_next)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gray_r <= '0;
      bin_r  <= '0;
      ptr_r  <= '0;
    end else begin
      gray_r <= gray_ptr_i;
      bin_r  <= bin_next;
      if (yumi_i && v_o) begin
        ptr_r <= ptr_r + 1'b1;
      end
    end
  end

  // Modulo subtraction absorbs producer pointer wrap past zero
  assign count_o = bin_r - ptr_r;
  assign v_o     = |count_o;
  assign ptr_o   = ptr_r;

  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
    else $error("bsg_sync_gray_ptr_rx: yumi_i asserted with nothing pending");

`ifdef BSG_SYNC_GRAY_PTR_RX_CHECK_EN
  logic        error_r;
  logic [31:0] diff_ext;
  logic [5:0]  diff_ones;

  assign diff_ext  = 32'(gray_ptr_i ^ gray_r);
  assign diff_ones = popcount32(diff_ext);

  // A legal Gray stream changes at most one bit between consecutive samples
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else begin
      assert (diff_ones <= 6'd1)
        else $warning("bsg_sync_gray_ptr_rx: gray jump %b -> %b", gray_r, gray_ptr_i);
      if (diff_ones > 6'd1) begin
        error_r <= 1'b1;
      end
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule
